mix_engine: RTL and testbench
=============================

Name: mix_engine

Overview:
- Parametrised multi-lane iterative mixing engine: LANES words of WIDTH bits, seeded on start, scrambled over ROUNDS clock cycles.
- Each round is a constant-add step, a cross-lane add/subtract chain and a per-lane multiply-add.
- Sits behind a control FSM as a reusable scrambling/stress datapath.
- Generalises the fixed 8 x 32-bit free-running mixer into a start/done handshaked block with configurable lane count, width and round count.

Parameters:
- WIDTH, 32, bits per lane (>= 8).
- LANES, 8, number of lanes (>= 4).
- ROUNDS, 16, rounds per job (>= 1).
- SHL, 16, left-shift amount for the optional xor-shift step (< WIDTH).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- start  in  1  job request; sampled only while ready=1.
- seed_in  in  LANES*WIDTH  initial lane values; lane i = bits [i*WIDTH +: WIDTH].
- ready  out  1  high in IDLE; a start is accepted this cycle.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse; result valid.
- state_out  out  LANES*WIDTH  current lane registers, same packing as seed_in.
- round_cnt  out  $clog2(ROUNDS+1)  rounds completed in the current job.

Behaviour:
- Reset (rst_n=0, asynchronous, any state including mid-job): FSM=IDLE, all lanes=0, ready=1, busy=0, done=0, round_cnt=0. No partial result is retained; the job is lost.
- FSM states: IDLE, RUN, DONE.
- IDLE: on an edge with start=1, lanes <= seed_in, round_cnt <= 0, go to RUN. If start=0, stay in IDLE and hold the lanes.
- RUN: each edge applies one full round to the lanes and increments round_cnt. On the edge where round_cnt reaches ROUNDS, go to DONE.
- DONE: done=1 for exactly one cycle, ready=0; next edge goes to IDLE.
- Latency: start accepted at edge N; done is high in the cycle following edge N+ROUNDS. The next start can be accepted at edge N+ROUNDS+2.
- start in RUN or DONE is ignored; no queuing.
- state_out mirrors the lanes at all times. The final result holds through IDLE until the next accepted start.
- All arithmetic is modulo 2^WIDTH, unsigned; overflow wraps silently.
- Round function, with o[k] the lane values and all indices mod LANES:
  - Step A: o[i] = o[i] + i, for all i.
  - Step B (sequential chain, i = 0..LANES-1 in order): o[i] = o[i] + o[i-1] - o[i-2], each term using the most recently updated value. For i=0 this means the still-old o[LANES-1] and o[LANES-2]; for i=1, the new o[0] and the old o[LANES-1].
  - Step C: o[i] = o[i]*(2i+3) + (i+1), for all i; the product is truncated to WIDTH.
- The round is purely combinational from the lane registers; one round per cycle, no multicycle paths.

Optional Feature:
- Macro: MIX_XSHIFT_EN.
- Defined: an extra Step X runs between B and C, sequential over i = 0..LANES-1: o[i] = o[i] ^ (o[i+LANES/2] << SHL), using most-recent values and truncated to WIDTH.
- Undefined: Step X is absent and the round is A, B, C only. Ports and timing are identical in both builds.

Test Plan:
- WIDTH=8, LANES=4, ROUNDS=1, seed all 0, MIX_XSHIFT_EN off: start -> after one RUN edge, done pulses and state_out lanes = [4, 253, 3, 40] (lane0..lane3); round_cnt=1.
- Defaults, start pulse at edge N -> busy high for 16 cycles; done high only in the cycle after edge N+16; ready back high one cycle later.
- start held high continuously -> a new job is accepted only in IDLE cycles; no accept while busy or done; the previous result is overwritten only on the accept edge.
- rst_n driven low mid-RUN, asynchronous to clk -> lanes, round_cnt and done go to 0 immediately; ready=1 and no done pulse after release.
- Seed with all lanes 2^WIDTH-1, ROUNDS=1, LANES=4, WIDTH=8 -> result matches a reference model computed mod 256, wrap-around checked on every lane.
- MIX_XSHIFT_EN on, WIDTH=32, SHL=16 -> each lane matches a golden model; the bench checks the xor-shift effect on the upper 16 bits.

Source files
------------

// File: rtl/mix_engine.sv
// ============================================================================
// Module   : mix_engine
// Purpose  : Multi-lane iterative mixing engine with a start/done handshake.
//            The optional xor-shift step is enabled by defining MIX_XSHIFT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mix_engine #(
    parameter int WIDTH  = 32,
    parameter int LANES  = 8,
    parameter int ROUNDS = 16,
    parameter int SHL    = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [LANES*WIDTH-1:0]       seed_in,
    output logic                         ready,
    output logic                         busy,
    output logic                         done,
    output logic [LANES*WIDTH-1:0]       state_out,
    output logic [$clog2(ROUNDS+1)-1:0]  round_cnt
);

    localparam int c_CNT_W = $clog2(ROUNDS + 1);

    generate
        if (WIDTH < 8 || LANES < 4 || ROUNDS < 1 || SHL >= WIDTH) begin : g_param_check
            $error("mix_engine: illegal parameterisation");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                         r_state;
    state_t                         w_state_nxt;
    logic [LANES-1:0][WIDTH-1:0]    r_lanes;
    logic [LANES-1:0][WIDTH-1:0]    w_lanes_nxt;
    logic [LANES-1:0][WIDTH-1:0]    w_round;
    logic [c_CNT_W-1:0]             r_cnt;
    logic [c_CNT_W-1:0]             w_cnt_nxt;
    logic [c_CNT_W-1:0]             w_cnt_inc;

    // One full round; the chain steps deliberately reuse lanes already updated
    // earlier in the same loop.
    function automatic logic [LANES-1:0][WIDTH-1:0] f_round(
        input logic [LANES-1:0][WIDTH-1:0] s
    );
        logic [LANES-1:0][WIDTH-1:0] o;
        o = s;
        for (int i = 0; i < LANES; i++) begin
            o[i] = o[i] + WIDTH'(i);
        end
        for (int i = 0; i < LANES; i++) begin
            o[i] = o[i] + o[(i + LANES - 1) % LANES] - o[(i + LANES - 2) % LANES];
        end
`ifdef MIX_XSHIFT_EN
        for (int i = 0; i < LANES; i++) begin
            o[i] = o[i] ^ (o[(i + LANES / 2) % LANES] << SHL);
        end
`else
`endif
        for (int i = 0; i < LANES; i++) begin
            o[i] = o[i] * WIDTH'(2 * i + 3) + WIDTH'(i + 1);
        end
        return o;
    endfunction

    assign w_round   = f_round(r_lanes);
    assign w_cnt_inc = r_cnt + c_CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_lanes <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_lanes <= w_lanes_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_lanes_nxt = r_lanes;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_RUN;
                    w_lanes_nxt = seed_in;
                    w_cnt_nxt   = '0;
                end
            end
            S_RUN: begin
                w_lanes_nxt = w_round;
                w_cnt_nxt   = w_cnt_inc;
                if (w_cnt_inc == c_CNT_W'(ROUNDS)) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign ready     = (r_state == S_IDLE);
    assign busy      = (r_state == S_RUN);
    assign done      = (r_state == S_DONE);
    assign state_out = r_lanes;
    assign round_cnt = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_mix_engine.sv
// ============================================================================
// Module   : tb_mix_engine
// Purpose  : Self-checking bench for mix_engine (small 8x4x1 and default build).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mix_engine;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;

    logic         s_start = 1'b0;
    logic [31:0]  s_seed = '0;
    logic         s_ready, s_busy, s_done;
    logic [31:0]  s_state;
    logic [0:0]   s_cnt;

    logic         d_start = 1'b0;
    logic [255:0] d_seed = '0;
    logic         d_ready, d_busy, d_done;
    logic [255:0] d_state;
    logic [4:0]   d_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mix_engine #(.WIDTH(8), .LANES(4), .ROUNDS(1), .SHL(4)) dut_small (
        .clk(clk), .rst_n(rst_n), .start(s_start), .seed_in(s_seed),
        .ready(s_ready), .busy(s_busy), .done(s_done),
        .state_out(s_state), .round_cnt(s_cnt)
    );

    mix_engine dut_def (
        .clk(clk), .rst_n(rst_n), .start(d_start), .seed_in(d_seed),
        .ready(d_ready), .busy(d_busy), .done(d_done),
        .state_out(d_state), .round_cnt(d_cnt)
    );

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: the round rules applied lane by lane with masked 64-bit arithmetic.
    function automatic logic [255:0] model(input int w, input int l, input int r,
                                           input logic [255:0] seed);
        logic [63:0]  o [8];
        logic [63:0]  mask;
        logic [255:0] res;
        logic [255:0] t;
        mask = (64'd1 << w) - 64'd1;
        for (int i = 0; i < l; i++) o[i] = 64'(seed >> (i * w)) & mask;
        for (int n = 0; n < r; n++) begin
            for (int i = 0; i < l; i++) o[i] = (o[i] + 64'(i)) & mask;
            for (int i = 0; i < l; i++)
                o[i] = (o[i] + o[(i + l - 1) % l] - o[(i + l - 2) % l]) & mask;
`ifdef MIX_XSHIFT_EN
            for (int i = 0; i < l; i++)
                o[i] = (o[i] ^ (o[(i + l / 2) % l] << ((w == 8) ? 4 : 16))) & mask;
`endif
            for (int i = 0; i < l; i++)
                o[i] = (o[i] * 64'(2 * i + 3) + 64'(i + 1)) & mask;
        end
        res = '0;
        for (int i = 0; i < l; i++) begin
            t = 256'(o[i]);
            res = res | (t << (i * w));
        end
        return res;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_small(input logic [31:0] seed, input string tag);
        logic [255:0] exp;
        exp = model(8, 4, 1, {224'd0, seed});
        s_seed  = seed;
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        check({tag, ".busy"}, {255'd0, s_busy}, 256'd1);
        tick();
        check({tag, ".done"}, {255'd0, s_done}, 256'd1);
        check({tag, ".cnt"}, {255'd0, s_cnt}, 256'd1);
        check({tag, ".state"}, {224'd0, s_state}, exp);
        tick();
        check({tag, ".ready"}, {254'd0, s_ready, s_done}, 256'd2);
        check({tag, ".hold"}, {224'd0, s_state}, exp);
    endtask

    initial begin
        logic [255:0] s1, s2, r1, exp2;
        int           busy_cycles, accepts, dones, waited;

        repeat (2) tick();
        check("rst.small", {s_ready, s_busy, s_done, s_cnt, s_state}, {4'b1000, 32'd0});
        check("rst.def", {d_ready, d_busy, d_done, d_cnt, d_state}, {8'b1000_0000, 256'd0});
        #3 rst_n = 1'b1;
        tick();

`ifndef MIX_XSHIFT_EN
        check("vec.const", model(8, 4, 1, 256'd0), {224'd0, 8'd40, 8'd3, 8'd253, 8'd4});
`endif
        run_small(32'h0000_0000, "small.zero");
        run_small(32'hFFFF_FFFF, "small.ones");
        for (int k = 0; k < 4; k++) run_small($urandom, "small.rand");

        // Default build: latency and result of one job.
        for (int j = 0; j < 2; j++) begin
            for (int k = 0; k < 8; k++) d_seed[k*32 +: 32] = $urandom;
            s1 = d_seed;
            d_start = 1'b1;
            tick();
            d_start = 1'b0;
            busy_cycles = 0;
            for (int k = 0; k < 16; k++) begin
                if (d_busy && !d_done && !d_ready) busy_cycles++;
                tick();
            end
            check("def.busy_cycles", 256'(busy_cycles), 256'd16);
            check("def.done", {253'd0, d_ready, d_busy, d_done}, 256'd1);
            check("def.cnt", {251'd0, d_cnt}, 256'd16);
            r1 = model(32, 8, 16, s1);
            check("def.state", d_state, r1);
`ifdef MIX_XSHIFT_EN
            check("def.xs_upper", {240'd0, d_state[31:16]}, {240'd0, r1[31:16]});
`endif
            tick();
            check("def.ready_after", {253'd0, d_ready, d_busy, d_done}, 256'd4);
        end

        // start held high: accepts only from IDLE, result held until accept edge.
        for (int k = 0; k < 8; k++) d_seed[k*32 +: 32] = $urandom;
        s2 = d_seed;
        exp2 = model(32, 8, 16, s2);
        d_start = 1'b1;
        check("held.prev_result", d_state, r1);
        accepts = 0;
        dones = 0;
        for (int k = 0; k < 40; k++) begin
            if (d_ready) accepts++;
            if (d_done) begin
                dones++;
                check("held.result", d_state, exp2);
            end
            tick();
            if (k == 0) check("held.accept_seed", d_state, s2);
        end
        check("held.accepts", 256'(accepts), 256'd3);
        check("held.dones", 256'(dones), 256'd2);
        d_start = 1'b0;
        waited = 0;
        while (!d_ready && waited < 40) begin
            tick();
            waited++;
        end
        check("held.back_idle", {255'd0, d_ready}, 256'd1);

        // Asynchronous reset in the middle of a job.
        d_start = 1'b1;
        tick();
        d_start = 1'b0;
        repeat (5) tick();
        #3 rst_n = 1'b0;
        #1;
        check("arst.def", {d_ready, d_busy, d_done, d_cnt, d_state}, {8'b1000_0000, 256'd0});
        check("arst.small", {224'd0, s_state}, 256'd0);
        @(posedge clk);
        #4 rst_n = 1'b1;
        dones = 0;
        for (int k = 0; k < 25; k++) begin
            if (d_done) dones++;
            tick();
        end
        check("arst.no_done", 256'(dones), 256'd0);
        check("arst.ready", {255'd0, d_ready}, 256'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
